// File: rtl/parking_gate_controller_pkg.sv
// Shared types for the parking lane/gate controller.
// FSM state encoding and lane direction constants.
package parking_gate_controller_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    CLOSE = 2'd2
  } state_t;

  localparam logic DIR_ENTRY = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

endpackage

// File: rtl/parking_gate_controller_gate_timer.sv
// Loadable down-counter shared by the open timeout and close delay.
// Expired flags the last cycle of a loaded interval.
module gate_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         res,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         expired
);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign expired = (value <= W'(1));

endmodule

// File: rtl/parking_gate_controller.sv
// Shared-lane gate sequencer: entry/exit arbitration,
// open timeout, close delay and occupancy tracking.
module parking_gate_controller
  import parking_gate_controller_pkg::*;
#(
  parameter int CAPACITY     = 100,
  parameter int COUNT_W      = 14,
  parameter int OPEN_TIMEOUT = 32,
  parameter int CLOSE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               res,
  input  logic               entry_req,
  input  logic               exit_req,
  input  logic               pass_done,
  output logic               gate_open,
  output logic               dir,
  output logic               entry_grant,
  output logic               exit_grant,
  output logic               timeout_err,
  output logic [COUNT_W-1:0] occupancy,
  output logic               lot_full
);

  localparam int TMR_MAX =
    (OPEN_TIMEOUT > CLOSE_CYCLES) ? OPEN_TIMEOUT : CLOSE_CYCLES;
  localparam int TMR_W = $clog2(TMR_MAX + 1);
  localparam logic [COUNT_W:0] CAP_V = (COUNT_W + 1)'(CAPACITY);

  state_t             state, state_n;
  logic               last_dir, last_n;
  logic               gate_n, dir_n;
  logic               eg_n, xg_n, to_n;
  logic [COUNT_W-1:0] occ_n;
  logic               t_load;
  logic [TMR_W-1:0]   t_val;
  logic [TMR_W-1:0]   t_value;
  logic               t_expired;
  logic               ent_ok, pick_exit, pick_entry;

  gate_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .res      (res),
    .load     (t_load),
    .load_val (t_val),
    .value    (t_value),
    .expired  (t_expired)
  );

  // Exit wins a tie only when entry was served last
  assign ent_ok     = entry_req && !lot_full;
  assign pick_exit  = exit_req && (!ent_ok || last_dir == DIR_ENTRY);
  assign pick_entry = ent_ok && !pick_exit;

  always_comb begin
    state_n = state;
    gate_n  = gate_open;
    dir_n   = dir;
    last_n  = last_dir;
    eg_n    = 1'b0;
    xg_n    = 1'b0;
    to_n    = 1'b0;
    occ_n   = occupancy;
    t_load  = 1'b0;
    t_val   = '0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          pick_exit: begin
            state_n = OPEN;
            gate_n  = 1'b1;
            dir_n   = DIR_EXIT;
            last_n  = DIR_EXIT;
            xg_n    = 1'b1;
            t_load  = 1'b1;
            t_val   = TMR_W'(OPEN_TIMEOUT);
          end
          pick_entry: begin
            state_n = OPEN;
            gate_n  = 1'b1;
            dir_n   = DIR_ENTRY;
            last_n  = DIR_ENTRY;
            eg_n    = 1'b1;
            t_load  = 1'b1;
            t_val   = TMR_W'(OPEN_TIMEOUT);
          end
          default: ;
        endcase
      end
      OPEN: begin
        if (pass_done || t_expired) begin
          state_n = CLOSE;
          gate_n  = 1'b0;
          t_load  = 1'b1;
          t_val   = TMR_W'(CLOSE_CYCLES);
        end
        if (pass_done) begin
          if (dir == DIR_ENTRY) begin
            if (occupancy != '1) occ_n = occupancy + COUNT_W'(1);
          end else begin
            if (occupancy != '0) occ_n = occupancy - COUNT_W'(1);
          end
        end else if (t_expired) begin
          to_n = 1'b1;
        end
      end
      CLOSE: begin
        if (t_expired) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state       <= IDLE;
      gate_open   <= 1'b0;
      dir         <= DIR_ENTRY;
      last_dir    <= DIR_EXIT;
      entry_grant <= 1'b0;
      exit_grant  <= 1'b0;
      timeout_err <= 1'b0;
      occupancy   <= '0;
      lot_full    <= (CAPACITY == 0);
    end else begin
      state       <= state_n;
      gate_open   <= gate_n;
      dir         <= dir_n;
      last_dir    <= last_n;
      entry_grant <= eg_n;
      exit_grant  <= xg_n;
      timeout_err <= to_n;
      occupancy   <= occ_n;
      lot_full    <= ({1'b0, occ_n} >= CAP_V);
    end
  end

endmodule

// File: doc/parking_gate_controller.md
# parking_gate_controller

Sequencing controller for the single shared lane and barrier gate of the parking lot. It arbitrates between an entry requester and an exit requester and opens the gate for one car at a time. It tracks lot occupancy from lane-clear pulses and refuses entry when the lot is full. It sits between the lane sensors/car-detection logic and the gate actuator.

## Interface
- `CAPACITY`, 100: maximum occupancy; entry is refused when occupancy >= CAPACITY.
- `COUNT_W`, 14: occupancy width; CAPACITY < 2^COUNT_W.
- `OPEN_TIMEOUT`, 32: cycles the gate may stay open waiting for `pass_done` before abort.
- `CLOSE_CYCLES`, 4: cycles spent closing before a new grant; must be >= 1.
- `clk` in 1: single system clock, rising edge.
- `res` in 1: reset, asynchronous, active-high.
- `entry_req` in 1: level; a car is waiting at the entry side.
- `exit_req` in 1: level; a car is waiting at the exit side.
- `pass_done` in 1: one-cycle pulse; the car has fully cleared the lane.
- `gate_open` out 1: barrier open command.
- `dir` out 1: lane direction of the current/last grant; 0 = entry, 1 = exit.
- `entry_grant` out 1: one-cycle pulse when an entry passage starts.
- `exit_grant` out 1: one-cycle pulse when an exit passage starts.
- `timeout_err` out 1: one-cycle pulse when a passage is aborted by timeout.
- `occupancy` out COUNT_W: cars currently in the lot.
- `lot_full` out 1: high when occupancy >= CAPACITY.

## Operation
- FSM states:
  - IDLE: gate closed, sampling requests.
  - OPEN: gate open, waiting for a car to clear.
  - CLOSE: gate closing.
- IDLE, eligibility: entry is eligible = `entry_req` && !`lot_full`; exit is eligible = `exit_req` (always allowed).
- IDLE, one eligible: grant it.
- IDLE, both eligible: grant the direction opposite to `last_dir` (round-robin).
- IDLE, none eligible: stay in IDLE.
- IDLE, on a grant: latch `dir`, set `last_dir` = granted direction, pulse the matching grant, go to OPEN, load the timer with OPEN_TIMEOUT.
- OPEN, on `pass_done`: go to CLOSE.
  - Entry: occupancy + 1, saturating at 2^COUNT_W-1.
  - Exit: occupancy - 1, saturating at 0; exit with occupancy 0 leaves it at 0.
- OPEN, timer expires with no `pass_done`: pulse `timeout_err`, go to CLOSE, leave occupancy unchanged.
- OPEN, `pass_done` on the expiry cycle: `pass_done` wins and no `timeout_err` is raised.
- CLOSE: hold CLOSE_CYCLES cycles, then go to IDLE. `pass_done` in IDLE or CLOSE is ignored.
- Requests that drop before a grant are simply not served; requests are not queued.
- `lot_full` is derived from the registered occupancy.

## Timing
- Reset values: state IDLE, `gate_open` 0, `dir` 0, `last_dir` 1 (entry wins the first tie), grants 0, `timeout_err` 0, `occupancy` 0, `lot_full` 0 (1 if CAPACITY = 0).
- All outputs are registered.
- Grant latency: request eligible in IDLE at edge N gives grant pulse, `gate_open` = 1, and `dir` valid after edge N+1.
- Pass latency: `pass_done` sampled at edge M gives `gate_open` = 0 and the occupancy update after edge M+1. `lot_full` follows in the same cycle as the occupancy.
- Timeout: with no `pass_done`, OPEN lasts exactly OPEN_TIMEOUT cycles; `timeout_err` coincides with the first cycle of `gate_open` = 0.
- Minimum grant-to-grant spacing is 1 + CLOSE_CYCLES + 1 cycles: one cycle OPEN if `pass_done` comes immediately, CLOSE_CYCLES in CLOSE, one IDLE decision cycle.
- `res` asserted mid-passage closes the gate at once and clears occupancy; there is no partial count update.

## Structure
- Shared package holds:
  - state encoding: IDLE, OPEN, CLOSE;
  - direction constants DIR_ENTRY = 0, DIR_EXIT = 1.
- One sub-module, `gate_timer`: loadable down-counter with `load`, `value`, and `expired` outputs. It is reused for both the open timeout and the close delay.
- Occupancy register and arbiter stay in the top module.

## Test plan
- Reset, then `entry_req` = 1 and `pass_done` 3 cycles after the grant -> one `entry_grant`, `gate_open` high 3 cycles, `occupancy` 0 -> 1, gate closed for 4 cycles.
- `entry_req` and `exit_req` held high together, passing each car immediately -> grants alternate entry, exit, entry, exit; `occupancy` toggles 1, 0, 1, 0.
- CAPACITY = 2, fill with two entries -> `lot_full` = 1; further `entry_req` gets no grant while `exit_req` is still granted; after the exit, `lot_full` = 0.
- Grant with no `pass_done` -> `timeout_err` pulses after exactly 32 open cycles, `occupancy` unchanged, gate closes.
- `exit_req` with `occupancy` 0, then `pass_done` -> `occupancy` stays 0 (saturation). A `pass_done` injected in IDLE has no effect.
- Assert `res` while OPEN with `occupancy` 5 -> `gate_open` 0 and `occupancy` 0 immediately, FSM in IDLE; next tie grants entry first.
